// File: rtl/anc_pkg.sv
// Shared definitions for the ANC inner-product datapath: tap depth, frame
// markers, default widths and the streamer FSM state type.
package anc_pkg;

   localparam int TAPS     = 126;
   localparam int X_W_DEF  = 16;
   localparam int W_W_DEF  = 16;

   localparam logic [6:0] FRAME_IDLE = 7'd0;
   localparam logic [6:0] FRAME_DONE = 7'd127;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } anc_state_e;

   // Circular pointer helpers over the 0..TAPS-1 range
   function automatic logic [6:0] ptrInc(input logic [6:0] p);
      return (p == 7'(TAPS - 1)) ? 7'd0 : p + 7'd1;
   endfunction

   function automatic logic [6:0] ptrDec(input logic [6:0] p);
      return (p == 7'd0) ? 7'(TAPS - 1) : p - 7'd1;
   endfunction

endpackage

// File: rtl/anc_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old word.
module anc_dpram #(
   parameter int DEPTH = 126,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Out-of-range addresses are ignored on both ports
   always_ff @(posedge clk) begin
      if (we_i && (32'(waddr_i) < DEPTH)) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i && (32'(raddr_i) < DEPTH)) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/anc_tap_streamer.sv
// Producer side of the ANC inner product: pushes each reference sample into a
// circular delay line and streams (x[n-k], w[k]) pairs with a frame index.
module anc_tap_streamer
   import anc_pkg::*;
#(
   parameter int X_W = X_W_DEF,
   parameter int W_W = W_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sample_valid_i,
   input  logic signed [X_W-1:0] sample_in_i,
   input  logic                  coef_we_i,
   input  logic [6:0]            coef_addr_i,
   input  logic signed [W_W-1:0] coef_wdata_i,
   output logic [6:0]            frame_o,
   output logic signed [X_W-1:0] x_out_o,
   output logic signed [W_W-1:0] w_out_o,
   output logic                  y_valid_o,
   output logic                  busy_o,
   output logic                  overrun_o
);

   anc_state_e state_q, state_d;
   logic [6:0] k_q, k_d;
   logic [6:0] rd_ptr_q, rd_ptr_d;
   logic [6:0] wr_ptr_q, wr_ptr_d;
   logic [6:0] fill_q, fill_d;

   logic       s1_valid_q;
   logic [6:0] s1_tap_q;
   logic       s1_mask_q;

   logic [6:0]            frame_q, frame_d;
   logic signed [X_W-1:0] x_out_q, x_out_d;
   logic signed [W_W-1:0] w_out_q, w_out_d;
   logic                  y_valid_q, y_valid_d;
   logic                  busy_q;
   logic                  overrun_q;

   logic           accept;
   logic           drop;
   logic           rd_en;
   logic [6:0]     wr_next;
   logic [6:0]     wr_eff;
   logic [X_W-1:0] x_rdata;
   logic [W_W-1:0] w_rdata;

   // wr_ptr advances as DONE is left; a sample accepted in that same cycle
   // must already land on the advanced slot or it would overwrite the last one.
   assign wr_next = ptrInc(wr_ptr_q);
   assign wr_eff  = (state_q == ST_DONE) ? wr_next : wr_ptr_q;
   assign accept  = sample_valid_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign drop    = sample_valid_i && ((state_q == ST_PRIME) || (state_q == ST_STREAM));
   assign rd_en   = (state_q == ST_PRIME) ||
                    ((state_q == ST_STREAM) && (k_q < 7'(TAPS)));

   anc_dpram #(.DEPTH(TAPS), .WIDTH(X_W)) u_delay_line (
      .clk     (clk),
      .we_i    (accept),
      .waddr_i (wr_eff),
      .wdata_i (sample_in_i),
      .re_i    (rd_en),
      .raddr_i (rd_ptr_q),
      .rdata_o (x_rdata)
   );

   anc_dpram #(.DEPTH(TAPS), .WIDTH(W_W)) u_coef_ram (
      .clk     (clk),
      .we_i    (coef_we_i),
      .waddr_i (coef_addr_i),
      .wdata_i (coef_wdata_i),
      .re_i    (rd_en),
      .raddr_i (k_q),
      .rdata_o (w_rdata)
   );

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_PRIME: begin
            state_d  = ST_STREAM;
            k_d      = k_q + 7'd1;
            rd_ptr_d = ptrDec(rd_ptr_q);
         end
         ST_STREAM: begin
            // k reaching TAPS is the drain cycle that lets the last tap reach the outputs
            if (k_q == 7'(TAPS)) begin
               state_d = ST_DONE;
            end else begin
               k_d      = k_q + 7'd1;
               rd_ptr_d = ptrDec(rd_ptr_q);
            end
         end
         ST_DONE: begin
            wr_ptr_d = wr_next;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         state_d  = ST_PRIME;
         k_d      = 7'd0;
         rd_ptr_d = wr_eff;
         if (fill_q != 7'(TAPS)) begin
            fill_d = fill_q + 7'd1;
         end
      end
   end

   // Outputs lag the FSM by one stage because of the synchronous RAM read
   always_comb begin
      frame_d   = FRAME_IDLE;
      x_out_d   = '0;
      w_out_d   = '0;
      y_valid_d = 1'b0;
      if (s1_valid_q) begin
         frame_d = s1_tap_q + 7'd1;
         x_out_d = s1_mask_q ? '0 : x_rdata;
         w_out_d = w_rdata;
      end else if (state_q == ST_DONE) begin
         frame_d   = FRAME_DONE;
         y_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         k_q        <= 7'd0;
         rd_ptr_q   <= 7'd0;
         wr_ptr_q   <= 7'd0;
         fill_q     <= 7'd0;
         s1_valid_q <= 1'b0;
         s1_tap_q   <= 7'd0;
         s1_mask_q  <= 1'b0;
         frame_q    <= FRAME_IDLE;
         x_out_q    <= '0;
         w_out_q    <= '0;
         y_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_q     <= fill_d;
         s1_valid_q <= rd_en;
         s1_tap_q   <= k_q;
         s1_mask_q  <= (k_q >= fill_q);
         frame_q    <= frame_d;
         x_out_q    <= x_out_d;
         w_out_q    <= w_out_d;
         y_valid_q  <= y_valid_d;
         busy_q     <= (state_q != ST_IDLE);
         overrun_q  <= drop;
      end
   end

   assign frame_o   = frame_q;
   assign x_out_o   = x_out_q;
   assign w_out_o   = w_out_q;
   assign y_valid_o = y_valid_q;
   assign busy_o    = busy_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_anc_tap_streamer.sv
// Directed bench for anc_tap_streamer: captures each run, models the
// downstream accumulator, and compares against hand-computed tap/sum tables.
module tb_anc_tap_streamer;
   import anc_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sampleValid = 1'b0;
   logic signed [15:0] sampleIn = '0;
   logic coefWe = 1'b0;
   logic [6:0] coefAddr = '0;
   logic signed [15:0] coefWdata = '0;
   logic [6:0] frame;
   logic signed [15:0] xOut;
   logic signed [15:0] wOut;
   logic yValid;
   logic busy;
   logic overrun;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int                 runId;
      int                 frameNo;
      logic signed [15:0] expX;
      logic signed [15:0] expW;
   } probe_t;
   probe_t probes[$];

   logic signed [15:0] xCap [0:127];
   logic signed [15:0] wCap [0:127];
   longint sumCap, sumAtDone;
   int streamCount, firstStep, busyCount, overrunCount, overrunFrame, yCount;
   bit seqOk, busyAfter, runDone;
   logic [6:0] frameAfter;
   logic signed [15:0] doneX, doneW;

   anc_tap_streamer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sample_valid_i (sampleValid),
      .sample_in_i    (sampleIn),
      .coef_we_i      (coefWe),
      .coef_addr_i    (coefAddr),
      .coef_wdata_i   (coefWdata),
      .frame_o        (frame),
      .x_out_o        (xOut),
      .w_out_o        (wOut),
      .y_valid_o      (yValid),
      .busy_o         (busy),
      .overrun_o      (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic writeCoef(input logic [6:0] addr, input logic signed [15:0] data);
      coefWe = 1'b1;
      coefAddr = addr;
      coefWdata = data;
      step();
      coefWe = 1'b0;
   endtask

   task automatic startSample(input logic signed [15:0] val);
      sampleValid = 1'b1;
      sampleIn = val;
      step();
      sampleValid = 1'b0;
   endtask

   // Follows one run, optionally injecting a dropped sample, a coefficient
   // write, or a back-to-back sample keyed on the frame currently shown.
   task automatic followRun(input int dropFrame, input int coefFrame,
                            input logic [6:0] cAddr, input logic signed [15:0] cData,
                            input bit bb, input logic signed [15:0] bbVal);
      int expNext;
      expNext = 1;
      seqOk = 1'b1;
      streamCount = 0;
      sumCap = 0;
      sumAtDone = 0;
      firstStep = -1;
      busyCount = 0;
      overrunCount = 0;
      overrunFrame = -1;
      yCount = 0;
      runDone = 1'b0;
      for (int i = 0; i < 128; i++) begin
         xCap[i] = '0;
         wCap[i] = '0;
      end
      for (int s = 1; s <= 200 && !runDone; s++) begin
         if (dropFrame > 0 && frame == dropFrame) begin
            sampleValid = 1'b1;
            sampleIn = 16'sd999;
         end
         if (bb && frame == 7'd126) begin
            sampleValid = 1'b1;
            sampleIn = bbVal;
         end
         if (coefFrame > 0 && frame == coefFrame) begin
            coefWe = 1'b1;
            coefAddr = cAddr;
            coefWdata = cData;
         end
         step();
         sampleValid = 1'b0;
         coefWe = 1'b0;
         if (busy) busyCount++;
         if (overrun) begin
            overrunCount++;
            overrunFrame = int'(frame);
         end
         if (yValid) yCount++;
         if (frame >= 7'd1 && frame <= 7'd126) begin
            if (firstStep < 0) firstStep = s;
            if (int'(frame) != expNext) seqOk = 1'b0;
            expNext++;
            streamCount++;
            xCap[frame] = xOut;
            wCap[frame] = wOut;
            sumCap += longint'(xOut) * longint'(wOut);
         end else if (frame == 7'd127) begin
            sumAtDone = sumCap;
            doneX = xOut;
            doneW = wOut;
            step();
            frameAfter = frame;
            busyAfter = busy;
            runDone = 1'b1;
         end
      end
      check("runCompletes", runDone, 1);
   endtask

   task automatic pushRun(input logic signed [15:0] val);
      startSample(val);
      followRun(0, 0, 7'd0, 16'sd0, 1'b0, 16'sd0);
   endtask

   task automatic checkOutput(input string tag, input int runId, input longint expSum,
                              input int expFirst, input int expBusy, input int expOverrun,
                              input bit backToBack);
      check({tag, ".frameSeq"}, seqOk, 1);
      check({tag, ".streamCount"}, streamCount, 126);
      check({tag, ".firstFrameStep"}, firstStep, expFirst);
      check({tag, ".sum"}, sumAtDone, expSum);
      check({tag, ".yValidCycles"}, yCount, 1);
      check({tag, ".doneX"}, doneX, 0);
      check({tag, ".doneW"}, doneW, 0);
      check({tag, ".busyCycles"}, busyCount, expBusy);
      check({tag, ".overrunPulses"}, overrunCount, expOverrun);
      check({tag, ".busyAfterDone"}, busyAfter, backToBack ? 1 : 0);
      if (!backToBack) check({tag, ".frameAfterDone"}, frameAfter, 0);
      foreach (probes[i]) begin
         if (probes[i].runId == runId) begin
            check($sformatf("%s.x@%0d", tag, probes[i].frameNo), xCap[probes[i].frameNo], probes[i].expX);
            check($sformatf("%s.w@%0d", tag, probes[i].frameNo), wCap[probes[i].frameNo], probes[i].expW);
         end
      end
   endtask

   task automatic applyStimulus();
      bit hit;
      // Reset state
      step();
      step();
      check("reset.frame", frame, 0);
      check("reset.x", xOut, 0);
      check("reset.w", wOut, 0);
      check("reset.yValid", yValid, 0);
      check("reset.busy", busy, 0);
      check("reset.overrun", overrun, 0);
      rst_n = 1'b1;
      step();

      // Single sample with unit coefficients; unwritten taps read as zero
      for (int k = 0; k < 126; k++) writeCoef(7'(k), 16'sd1);
      writeCoef(7'd126, 16'sd77);
      startSample(16'sd100);
      followRun(0, 0, 7'd0, 16'sd0, 1'b0, 16'sd0);
      checkOutput("single", 1, 100, 2, 128, 0, 1'b0);

      // Full delay line of ones then a 2, with ramp coefficients
      for (int k = 0; k < 126; k++) writeCoef(7'(k), 16'(k));
      for (int n = 0; n < 126; n++) pushRun(16'sd1);
      startSample(16'sd2);
      followRun(0, 0, 7'd0, 16'sd0, 1'b0, 16'sd0);
      checkOutput("full", 2, 7875, 2, 128, 0, 1'b0);

      // Asynchronous reset in the middle of a run
      startSample(16'sd55);
      hit = 1'b0;
      for (int s = 0; s < 200 && !hit; s++) begin
         step();
         if (frame == 7'd60) hit = 1'b1;
      end
      check("midReset.reachFrame60", hit, 1);
      rst_n = 1'b0;
      #1;
      check("midReset.frame", frame, 0);
      check("midReset.busy", busy, 0);
      check("midReset.x", xOut, 0);
      check("midReset.w", wOut, 0);
      step();
      rst_n = 1'b1;
      step();
      startSample(16'sd1);
      followRun(0, 0, 7'd0, 16'sd0, 1'b0, 16'sd0);
      checkOutput("afterReset", 4, 0, 2, 128, 0, 1'b0);

      // Write pointer wrap
      for (int n = 2; n <= 129; n++) pushRun(16'(n));
      startSample(16'sd130);
      followRun(0, 0, 7'd0, 16'sd0, 1'b0, 16'sd0);
      checkOutput("wrap", 3, 364875, 2, 128, 0, 1'b0);

      // Sample dropped mid-stream
      startSample(16'sd131);
      followRun(50, 0, 7'd0, 16'sd0, 1'b0, 16'sd0);
      checkOutput("overrun", 0, 372750, 2, 128, 1, 1'b0);
      check("overrun.frame", overrunFrame, 51);

      // Coefficient write colliding with its own read
      startSample(16'sd132);
      followRun(0, 9, 7'd10, 16'sd1000, 1'b0, 16'sd0);
      checkOutput("coefOld", 5, 380625, 2, 128, 0, 1'b0);

      // Back-to-back: next sample presented during DONE
      startSample(16'sd133);
      followRun(0, 0, 7'd0, 16'sd0, 1'b1, 16'sd134);
      checkOutput("b2bFirst", 6, 510270, 2, 128, 0, 1'b1);
      followRun(0, 0, 7'd0, 16'sd0, 1'b0, 16'sd0);
      checkOutput("b2bSecond", 7, 519135, 1, 127, 0, 1'b0);
   endtask

   initial begin
      probes.push_back('{1, 1, 16'sd100, 16'sd1});
      probes.push_back('{1, 2, 16'sd0, 16'sd1});
      probes.push_back('{1, 63, 16'sd0, 16'sd1});
      probes.push_back('{1, 126, 16'sd0, 16'sd1});
      probes.push_back('{2, 1, 16'sd2, 16'sd0});
      probes.push_back('{2, 2, 16'sd1, 16'sd1});
      probes.push_back('{2, 126, 16'sd1, 16'sd125});
      probes.push_back('{4, 1, 16'sd1, 16'sd0});
      probes.push_back('{4, 2, 16'sd0, 16'sd1});
      probes.push_back('{4, 126, 16'sd0, 16'sd125});
      probes.push_back('{3, 1, 16'sd130, 16'sd0});
      probes.push_back('{3, 2, 16'sd129, 16'sd1});
      probes.push_back('{3, 126, 16'sd5, 16'sd125});
      probes.push_back('{5, 11, 16'sd122, 16'sd10});
      probes.push_back('{6, 1, 16'sd133, 16'sd0});
      probes.push_back('{6, 11, 16'sd123, 16'sd1000});
      probes.push_back('{7, 1, 16'sd134, 16'sd0});
      probes.push_back('{7, 2, 16'sd133, 16'sd1});
      probes.push_back('{7, 11, 16'sd124, 16'sd1000});

      applyStimulus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
